// File: rtl/seq_alu.sv
// Sequential ALU with a valid/ready request and result handshake.
// Single-cycle ops resolve at acceptance; MUL runs an unsigned shift-add
// sequence, one partial product per clock, before presenting its result.
// The result and flags are held in DONE until the consumer takes them.
module seq_alu #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op_select,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic             cout,
   output logic             sign,
   output logic             overflow,
   output logic             zero,
   output logic             illegal
);

   localparam int SHW    = $clog2(WIDTH);
   localparam int MSB    = WIDTH - 1;
   localparam int LAST_I = WIDTH - 1;

   localparam logic [3:0] OP_ABS = 4'd0;
   localparam logic [3:0] OP_SHL = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_ADD = 4'd6;
   localparam logic [3:0] OP_SUB = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_SAR = 4'd9;

   localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH:0]   ONE_W1    = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] W_CONST   = WIDTH[WIDTH-1:0];
   localparam logic [SHW-1:0]   CNT_ONE   = {{(SHW-1){1'b0}}, 1'b1};
   localparam logic [SHW-1:0]   LAST_ITER = LAST_I[SHW-1:0];

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic accept;
   logic mul_last;

   // Result and flag registers presented to the consumer
   logic [WIDTH-1:0] out_reg, out_hi_reg;
   logic             cout_reg, sign_reg, overflow_reg, zero_reg, illegal_reg;

   // Shift-add multiplier: acc_hi_reg/acc_lo_reg form the running product,
   // acc_lo_reg starts as the multiplier and is shifted out LSB first.
   logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg, mcand_reg;
   logic [SHW-1:0]   cnt_reg;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] step_hi, step_lo;

   // Combinational single-cycle ALU, fed straight from the request inputs
   logic [WIDTH-1:0] and_vec, or_vec, xor_vec, not_vec;
   logic [WIDTH-1:0] neg_a, shl_val, sar_val;
   logic [WIDTH:0]   add_ext, sub_ext;
   logic [SHW-1:0]   shamt;
   logic             shift_oob;
   logic [WIDTH-1:0] alu_out;
   logic             alu_cout, alu_ovf, alu_illegal;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
         assign and_vec[gi] = a[gi] & b[gi];
         assign or_vec[gi]  = a[gi] | b[gi];
         assign xor_vec[gi] = a[gi] ^ b[gi];
         assign not_vec[gi] = ~a[gi];
      end
   endgenerate

   assign shamt     = b[SHW-1:0];
   // The whole of b is compared so that large shift requests saturate
   assign shift_oob = (b >= W_CONST);
   assign neg_a     = ~a + ONE_W;
   assign shl_val   = a << shamt;
   // Kept as its own signal so the arithmetic shift stays signed
   assign sar_val   = $signed(a) >>> shamt;
   assign add_ext   = {1'b0, a} + {1'b0, b};
   assign sub_ext   = {1'b0, a} + {1'b0, ~b} + ONE_W1;

   // Decode the opcode into result, carry, overflow and illegal flags
   always_comb begin
      alu_out     = '0;
      alu_cout    = 1'b0;
      alu_ovf     = 1'b0;
      alu_illegal = 1'b0;
      case (op_select)
         OP_ABS: begin
            alu_out = a[MSB] ? neg_a : a;
            alu_ovf = (a == MIN_NEG);
         end
         OP_SHL: alu_out = shift_oob ? '0 : shl_val;
         OP_SAR: alu_out = shift_oob ? {WIDTH{a[MSB]}} : sar_val;
         OP_AND: alu_out = and_vec;
         OP_OR:  alu_out = or_vec;
         OP_XOR: alu_out = xor_vec;
         OP_NOT: alu_out = not_vec;
         OP_ADD: begin
            alu_out  = add_ext[WIDTH-1:0];
            alu_cout = add_ext[WIDTH];
            alu_ovf  = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
         end
         OP_SUB: begin
            alu_out  = sub_ext[WIDTH-1:0];
            alu_cout = sub_ext[WIDTH];
            alu_ovf  = (a[MSB] != b[MSB]) && (sub_ext[MSB] != a[MSB]);
         end
         OP_MUL: alu_out = '0;
         default: alu_illegal = 1'b1;
      endcase
   end

   // One shift-add step: conditionally add the multiplicand, shift right
   assign mul_sum = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, mcand_reg} : '0);
   assign step_hi = mul_sum[WIDTH:1];
   assign step_lo = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // FSM next-state and handshake outputs
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      mul_last   = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept     = 1'b1;
               state_next = (op_select == OP_MUL) ? MUL_RUN : DONE;
            end
         end
         MUL_RUN: begin
            if (cnt_reg == LAST_ITER) begin
               mul_last   = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: load single-cycle results, or seed/step/finish the multiplier
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_reg      <= '0;
         out_hi_reg   <= '0;
         cout_reg     <= 1'b0;
         sign_reg     <= 1'b0;
         overflow_reg <= 1'b0;
         zero_reg     <= 1'b1;
         illegal_reg  <= 1'b0;
         acc_hi_reg   <= '0;
         acc_lo_reg   <= '0;
         mcand_reg    <= '0;
         cnt_reg      <= '0;
      end else if (accept) begin
         if (op_select == OP_MUL) begin
            acc_hi_reg <= '0;
            acc_lo_reg <= b;
            mcand_reg  <= a;
            cnt_reg    <= '0;
         end else begin
            out_reg      <= alu_out;
            out_hi_reg   <= '0;
            cout_reg     <= alu_cout;
            sign_reg     <= alu_out[MSB];
            overflow_reg <= alu_ovf;
            zero_reg     <= (alu_out == '0) && !alu_illegal;
            illegal_reg  <= alu_illegal;
         end
      end else if (state_reg == MUL_RUN) begin
         acc_hi_reg <= step_hi;
         acc_lo_reg <= step_lo;
         cnt_reg    <= cnt_reg + CNT_ONE;
         if (mul_last) begin
            out_reg      <= step_lo;
            out_hi_reg   <= step_hi;
            cout_reg     <= 1'b0;
            sign_reg     <= step_lo[MSB];
            overflow_reg <= (step_hi != '0);
            zero_reg     <= ({step_hi, step_lo} == '0);
            illegal_reg  <= 1'b0;
         end
      end
   end

   assign out      = out_reg;
   assign out_hi   = out_hi_reg;
   assign cout     = cout_reg;
   assign sign     = sign_reg;
   assign overflow = overflow_reg;
   assign zero     = zero_reg;
   assign illegal  = illegal_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: directed scenarios plus random ops, checked against
// an arithmetic reference model of the ALU rules.
module tb_seq_alu;

   localparam int W = 12;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   op_select;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic [W-1:0] out_hi;
   logic         cout, sign, overflow, zero, illegal;
   logic [4:0]   flags_obs;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [W-1:0] o;
      logic [W-1:0] hi;
      logic [4:0]   fl;   // {cout, sign, overflow, zero, illegal}
   } res_t;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op_select (op_select),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_hi    (out_hi),
      .cout      (cout),
      .sign      (sign),
      .overflow  (overflow),
      .zero      (zero),
      .illegal   (illegal)
   );

   assign flags_obs = {cout, sign, overflow, zero, illegal};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain integer arithmetic on the operand values
   function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic [3:0] mop);
      res_t   res;
      longint modv, half, ua, ub, sa, sb, r, p, hi;
      int     k;
      logic   c, v, z, il;
      modv = longint'(1) << W;
      half = modv / 2;
      ua = longint'(ma);
      ub = longint'(mb);
      sa = (ua >= half) ? ua - modv : ua;
      sb = (ub >= half) ? ub - modv : ub;
      r = 0; hi = 0; c = 0; v = 0; il = 0; p = 0;
      case (mop)
         4'd0: begin r = ((sa < 0) ? -sa : sa) % modv; v = (sa == -half); end
         4'd1: r = (ub >= W) ? 0 : (ua * (longint'(1) << ub)) % modv;
         4'd2: r = ua & ub;
         4'd3: r = ua | ub;
         4'd4: r = ua ^ ub;
         4'd5: r = (~ua) & (modv - 1);
         4'd6: begin
            r = (ua + ub) % modv;
            c = (ua + ub) >= modv;
            v = ((sa + sb) >= half) || ((sa + sb) < -half);
         end
         4'd7: begin
            r = (ua - ub + modv) % modv;
            c = (ua >= ub);
            v = ((sa - sb) >= half) || ((sa - sb) < -half);
         end
         4'd8: begin
            p  = ua * ub;
            r  = p % modv;
            hi = p / modv;
            v  = (hi != 0);
         end
         4'd9: begin
            k = (ub >= W) ? W - 1 : int'(ub);
            r = (sa >>> k) & (modv - 1);
         end
         default: il = 1;
      endcase
      if (il)            z = 0;
      else if (mop == 8) z = (p == 0);
      else               z = (r == 0);
      res.o  = r[W-1:0];
      res.hi = hi[W-1:0];
      res.fl = {c, r[W-1], v, z, il};
      return res;
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_in_ready"},  64'(in_ready),  64'(1'b1));
      chk({tag, "_out_valid"}, 64'(out_valid), 64'(1'b0));
      chk({tag, "_out"},       64'(out),       64'(0));
      chk({tag, "_out_hi"},    64'(out_hi),    64'(0));
      chk({tag, "_flags"},     64'(flags_obs), 64'(5'b00010));
   endtask

   // Issue one op, scramble inputs after acceptance, check latency, result,
   // stability during a stalled DONE, and return to IDLE.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input logic [3:0] top, input int hold);
      res_t e;
      int   lat;
      bit   rdy_seen;
      e = model(ta, tbv, top);
      a = ta; b = tbv; op_select = top; in_valid = 1'b1;
      tick();
      in_valid  = 1'b0;
      a         = W'($urandom);
      b         = W'($urandom);
      op_select = 4'($urandom);
      lat = 1;
      rdy_seen = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_seen = 1;
         out_ready = 1'($urandom);
         tick();
         lat++;
      end
      out_ready = 1'b0;
      $display("op=%0d a=%03h b=%03h -> out=%03h hi=%03h flags=%05b lat=%0d",
               top, ta, tbv, out, out_hi, flags_obs, lat);
      chk($sformatf("latency_op%0d", top), 64'(lat), 64'((top == 4'd8) ? W + 1 : 1));
      chk($sformatf("busy_ready_op%0d", top), 64'(rdy_seen), 64'(0));
      chk($sformatf("out_op%0d", top),    64'(out),       64'(e.o));
      chk($sformatf("out_hi_op%0d", top), 64'(out_hi),    64'(e.hi));
      chk($sformatf("flags_op%0d", top),  64'(flags_obs), 64'(e.fl));
      for (int i = 0; i < hold; i++) begin
         in_valid  = 1'b1;
         a         = W'($urandom);
         b         = W'($urandom);
         op_select = 4'($urandom);
         tick();
         chk($sformatf("hold_valid_%0d", i), 64'({out_valid, in_ready}), 64'(2'b10));
         chk($sformatf("hold_result_%0d", i), 64'({out, out_hi, flags_obs}), 64'(e));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("release_op%0d", top), 64'({out_valid, in_ready}), 64'(2'b01));
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic [3:0]   rop;
      bit           seen;

      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; op_select = '0;
      #2 rst_n = 1'b0;
      #1 check_reset("por");
      tick();
      rst_n = 1'b1;
      tick();

      // Scenarios 1-4
      run_op(12'h69F, 12'h769, 4'd6, 0);
      run_op(12'h800, 12'h000, 4'd0, 0);
      run_op(12'hEF1, 12'h000, 4'd0, 0);
      run_op(12'h815, 12'h76B, 4'd7, 0);
      run_op(12'h0FF, 12'h010, 4'd8, 0);

      // Boundaries: shift saturation, MUL extremes, carry wrap, illegal ops
      run_op(12'h5A3, 12'd12,  4'd1, 0);
      run_op(12'h5A3, 12'd11,  4'd1, 0);
      run_op(12'h800, 12'd12,  4'd9, 0);
      run_op(12'h9C4, 12'd0,   4'd9, 0);
      run_op(12'hFFF, 12'hFFF, 4'd8, 0);
      run_op(12'h000, 12'h7AB, 4'd8, 0);
      run_op(12'h800, 12'h800, 4'd6, 0);
      run_op(12'h123, 12'h456, 4'd12, 0);
      run_op(12'h000, 12'h000, 4'd15, 1);

      // Random ops against the reference model
      for (int n = 0; n < 40; n++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = W'($urandom);
         rb  = ((rop == 4'd1) || (rop == 4'd9)) ? W'($urandom_range(0, W + 3)) : W'($urandom);
         run_op(ra, rb, rop, int'($urandom_range(0, 2)));
      end

      // Scenario 5: consumer stalls for 5 cycles
      run_op(12'h69F, 12'h769, 4'd6, 5);

      // Scenario 6: reset in cycle 6 of a MUL
      a = 12'h0FF; b = 12'h010; op_select = 4'd8; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      chk("s6_running", 64'({out_valid, in_ready}), 64'(2'b00));
      rst_n = 1'b0;
      #1 check_reset("s6_rst");
      tick();
      tick();
      rst_n = 1'b1;
      seen = 0;
      repeat (16) begin
         tick();
         if (out_valid) seen = 1;
      end
      $display("s6 reset abort: out_valid_seen=%0d", seen);
      chk("s6_no_valid", 64'(seen), 64'(0));
      chk("s6_ready", 64'(in_ready), 64'(1'b1));
      run_op(12'h001, 12'h001, 4'd6, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
